// File: rtl/ase_fifo_reader.sv
// Read-side engine for an ASE FIFO: credit-limited read issue, skid buffer, valid/ready output.
// Optional sequence checker on popped words, enabled by defining ASE_FIFO_READER_SEQCHK_EN.
module ase_fifo_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int RD_LATENCY = 1,
    parameter int SKID_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  drain_en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_valid,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [31:0]           rd_count,
    output logic                  err_unexp,
    output logic                  seq_err
);

    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CW = $clog2(SKID_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(SKID_DEPTH);
    localparam logic [PW-1:0] LAST_SLOT = PW'(SKID_DEPTH - 1);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("ase_fifo_reader: RD_LATENCY must be in 1..4");
    end
    if (SKID_DEPTH < RD_LATENCY + 2) begin : g_bad_depth
        $error("ase_fifo_reader: SKID_DEPTH must be >= RD_LATENCY+2");
    end

    logic                  active_q, active_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [CW-1:0]         occ_q, occ_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
    logic [31:0]           rd_count_q, rd_count_d;
    logic                  err_unexp_q, err_unexp_d;
    logic [CW:0]           credit_used;
    logic                  wr, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    // Credit counts reads in flight plus stored words; a pop this cycle is not credited.
    assign credit_used = {1'b0, inflight_q} + {1'b0, occ_q};
    assign fifo_rd_en  = active_q & drain_en & ~fifo_empty & (credit_used < DEPTH_C);

    assign out_valid = (occ_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign rd_count  = rd_count_q;
    assign err_unexp = err_unexp_q;

    always_comb begin
        active_d    = 1'b1;
        wr          = fifo_valid & (inflight_q != '0);
        pop         = (occ_q != '0) & out_ready;
        inflight_d  = inflight_q + CW'(fifo_rd_en) - CW'(wr);
        occ_d       = occ_q + CW'(wr) - CW'(pop);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_count_d  = rd_count_q;
        err_unexp_d = err_unexp_q | (fifo_valid & (inflight_q == '0));
        for (int i = 0; i < SKID_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr) begin
            mem_d[wr_ptr_q] = fifo_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d   = ptr_inc(rd_ptr_q);
            rd_count_d = rd_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q    <= 1'b0;
            inflight_q  <= '0;
            occ_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_count_q  <= '0;
            err_unexp_q <= 1'b0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            active_q    <= active_d;
            inflight_q  <= inflight_d;
            occ_q       <= occ_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_count_q  <= rd_count_d;
            err_unexp_q <= err_unexp_d;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

`ifdef ASE_FIFO_READER_SEQCHK_EN
    if (DATA_WIDTH < 32) begin : g_bad_width
        $error("ase_fifo_reader: sequence checker needs DATA_WIDTH >= 32");
    end

    logic [31:0] exp_idx_q, exp_idx_d;
    logic [31:0] first_bad_idx_q, first_bad_idx_d;
    logic        seq_err_q, seq_err_d;

    // Only the first mismatching index is kept; later ones are ignored.
    always_comb begin
        exp_idx_d       = exp_idx_q;
        first_bad_idx_d = first_bad_idx_q;
        seq_err_d       = seq_err_q;
        if (pop) begin
            exp_idx_d = exp_idx_q + 32'd1;
            if ((out_data[31:0] != exp_idx_q) && !seq_err_q) begin
                seq_err_d       = 1'b1;
                first_bad_idx_d = exp_idx_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_idx_q       <= '0;
            first_bad_idx_q <= '0;
            seq_err_q       <= 1'b0;
        end else begin
            exp_idx_q       <= exp_idx_d;
            first_bad_idx_q <= first_bad_idx_d;
            seq_err_q       <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule
